// File: rtl/mips_mc_pkg.sv
// Shared types and encodings for the multi-cycle MIPS control slice.
package mips_mc_pkg;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTE  = 4'd6,
        ALUWB    = 4'd7,
        BRANCH   = 4'd8,
        IMMEXEC  = 4'd9,
        IMMWB    = 4'd10,
        JUMP     = 4'd11
    } state_t;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10,
        ALUOP_OR    = 2'b11
    } aluop_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

endpackage

// File: rtl/mips_alu_decoder.sv
// Combinational ALU decoder: FSM-selected operation, or Funct-driven for R-type.
import mips_mc_pkg::*;

module mips_alu_decoder (
    input  aluop_t      aluop,
    input  logic [5:0]  funct,
    output logic [2:0]  alu_control,
    output logic        illegal
);

    always_comb begin
        alu_control = ALU_ADD;
        illegal     = 1'b0;
        case (aluop)
            ALUOP_ADD: alu_control = ALU_ADD;
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_OR:  alu_control = ALU_OR;
            ALUOP_FUNCT: begin
                case (funct)
                    F_ADD:   alu_control = ALU_ADD;
                    F_SUB:   alu_control = ALU_SUB;
                    F_AND:   alu_control = ALU_AND;
                    F_OR:    alu_control = ALU_OR;
                    F_SLT:   alu_control = ALU_SLT;
                    default: illegal     = 1'b1;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mips_mc_control.sv
// Multi-cycle MIPS control: Moore FSM sequencing memory, IR, PC and register-file writes.
import mips_mc_pkg::*;

module mips_mc_control #(
    parameter int OPW   = 6,
    parameter int ALUCW = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [OPW-1:0]   Opcode,
    input  logic [OPW-1:0]   Funct,
    input  logic             Zero,
    output logic             MemWrite,
    output logic             IorD,
    output logic             IRWrite,
    output logic             PCEn,
    output logic             RegWrite,
    output logic             RegDst,
    output logic             MemtoReg,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       PCSrc,
    output logic [ALUCW-1:0] ALUControl,
    output logic             IllegalOp,
    output logic [3:0]       State
);

    state_t     state_q, state_d;
    aluop_t     aluop;
    logic [2:0] dec_control;
    logic       dec_illegal;
    logic       bad_funct_q;
    logic       pc_write, branch, branch_ne;

    mips_alu_decoder u_alu_decoder (
        .aluop       (aluop),
        .funct       (Funct),
        .alu_control (dec_control),
        .illegal     (dec_illegal)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= FETCH;
            bad_funct_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == EXECUTE)
                bad_funct_q <= dec_illegal;
        end
    end

    assign State = state_q;

    always_comb begin
        state_d   = FETCH;
        aluop     = ALUOP_ADD;
        pc_write  = 1'b0;
        branch    = 1'b0;
        branch_ne = 1'b0;
        MemWrite  = 1'b0;
        IorD      = 1'b0;
        IRWrite   = 1'b0;
        RegWrite  = 1'b0;
        RegDst    = 1'b0;
        MemtoReg  = 1'b0;
        ALUSrcA   = 1'b0;
        ALUSrcB   = 2'b00;
        PCSrc     = 2'b00;
        IllegalOp = 1'b0;

        case (state_q)
            FETCH: begin
                IRWrite  = 1'b1;
                ALUSrcB  = 2'b01;
                pc_write = 1'b1;
                state_d  = DECODE;
            end
            DECODE: begin
                ALUSrcB = 2'b11;
                case (Opcode)
                    OP_LW, OP_SW:    state_d = MEMADR;
                    OP_RTYPE:        state_d = EXECUTE;
                    OP_BEQ, OP_BNE:  state_d = BRANCH;
                    OP_ADDI, OP_ORI: state_d = IMMEXEC;
                    OP_J:            state_d = JUMP;
                    default:         IllegalOp = 1'b1;
                endcase
            end
            MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                state_d = (Opcode == OP_SW) ? MEMWRITE : MEMREAD;
            end
            MEMREAD: begin
                IorD    = 1'b1;
                state_d = MEMWB;
            end
            MEMWB: begin
                MemtoReg = 1'b1;
                RegWrite = 1'b1;
            end
            MEMWRITE: begin
                IorD     = 1'b1;
                MemWrite = 1'b1;
            end
            EXECUTE: begin
                ALUSrcA   = 1'b1;
                aluop     = ALUOP_FUNCT;
                IllegalOp = dec_illegal;
                state_d   = ALUWB;
            end
            // Unknown funct was latched in EXECUTE so the write-back is dropped here.
            ALUWB: begin
                RegDst   = 1'b1;
                RegWrite = ~bad_funct_q;
            end
            BRANCH: begin
                ALUSrcA   = 1'b1;
                aluop     = ALUOP_SUB;
                PCSrc     = 2'b01;
                branch    = 1'b1;
                branch_ne = (Opcode == OP_BNE);
            end
            IMMEXEC: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                aluop   = (Opcode == OP_ORI) ? ALUOP_OR : ALUOP_ADD;
                state_d = IMMWB;
            end
            IMMWB:   RegWrite = 1'b1;
            JUMP: begin
                PCSrc    = 2'b10;
                pc_write = 1'b1;
            end
            default: state_d = FETCH;
        endcase

        PCEn       = pc_write | (branch & (Zero ^ branch_ne));
        ALUControl = dec_control;

        // Reset masks every output, including the FETCH strobes the state would imply.
        if (rst) begin
            MemWrite   = 1'b0;
            IorD       = 1'b0;
            IRWrite    = 1'b0;
            PCEn       = 1'b0;
            RegWrite   = 1'b0;
            RegDst     = 1'b0;
            MemtoReg   = 1'b0;
            ALUSrcA    = 1'b0;
            ALUSrcB    = 2'b00;
            PCSrc      = 2'b00;
            ALUControl = '0;
            IllegalOp  = 1'b0;
        end
    end

endmodule

// File: tb/tb_mips_mc_control.sv
// Directed-vector bench for the multi-cycle MIPS control unit.
import mips_mc_pkg::*;

module tb_mips_mc_control;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] Opcode = 6'b000000;
    logic [5:0] Funct = 6'b100000;
    logic       Zero = 1'b0;
    logic       MemWrite, IorD, IRWrite, PCEn, RegWrite, RegDst, MemtoReg, ALUSrcA, IllegalOp;
    logic [1:0] ALUSrcB, PCSrc;
    logic [2:0] ALUControl;
    logic [3:0] State;

    int errors = 0;
    int checks = 0;

    mips_mc_control #(.OPW(6), .ALUCW(3)) dut (
        .clk(clk), .rst(rst), .Opcode(Opcode), .Funct(Funct), .Zero(Zero),
        .MemWrite(MemWrite), .IorD(IorD), .IRWrite(IRWrite), .PCEn(PCEn),
        .RegWrite(RegWrite), .RegDst(RegDst), .MemtoReg(MemtoReg), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .PCSrc(PCSrc), .ALUControl(ALUControl),
        .IllegalOp(IllegalOp), .State(State)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (State !== 4'd0) begin errors++; $display("FAIL rst_state got=%0d exp=0", State); end
        checks++; if ({MemWrite, IRWrite, PCEn, RegWrite, IllegalOp} !== 5'b00000) begin errors++; $display("FAIL rst_strobes got=%b exp=00000", {MemWrite, IRWrite, PCEn, RegWrite, IllegalOp}); end
        checks++; if ({IorD, ALUSrcA, ALUSrcB, PCSrc, ALUControl} !== 9'b0) begin errors++; $display("FAIL rst_other got=%b exp=000000000", {IorD, ALUSrcA, ALUSrcB, PCSrc, ALUControl}); end
        rst = 1'b0;
        #1;
        checks++; if ({IRWrite, PCEn, IorD, ALUSrcB} !== 5'b11001) begin errors++; $display("FAIL fetch_after_rst got=%b exp=11001", {IRWrite, PCEn, IorD, ALUSrcB}); end
        checks++; if (ALUControl !== 3'b010) begin errors++; $display("FAIL fetch_alu got=%b exp=010", ALUControl); end
    endtask

    task automatic test_lw();
        Opcode = 6'b100011;
        step();
        checks++; if (State !== 4'(DECODE) || IRWrite !== 1'b0) begin errors++; $display("FAIL lw_decode state=%0d irw=%b exp state=%0d irw=0", State, IRWrite, DECODE); end
        step();
        checks++; if (State !== 4'(MEMADR) || {ALUSrcA, ALUSrcB, IorD} !== 4'b1100) begin errors++; $display("FAIL lw_memadr state=%0d ctl=%b exp ctl=1100", State, {ALUSrcA, ALUSrcB, IorD}); end
        step();
        checks++; if (State !== 4'(MEMREAD) || {IorD, RegWrite, MemWrite} !== 3'b100) begin errors++; $display("FAIL lw_memread state=%0d ctl=%b exp ctl=100", State, {IorD, RegWrite, MemWrite}); end
        step();
        checks++; if (State !== 4'(MEMWB) || {RegWrite, MemtoReg, RegDst, IorD, MemWrite} !== 5'b11000) begin errors++; $display("FAIL lw_memwb state=%0d ctl=%b exp ctl=11000", State, {RegWrite, MemtoReg, RegDst, IorD, MemWrite}); end
        step();
        checks++; if (State !== 4'(FETCH) || RegWrite !== 1'b0) begin errors++; $display("FAIL lw_done state=%0d rw=%b exp state=0 rw=0", State, RegWrite); end
    endtask

    task automatic test_sw();
        Opcode = 6'b101011;
        checks++; if (MemWrite !== 1'b0) begin errors++; $display("FAIL sw_c1 memwrite=%b exp=0", MemWrite); end
        step();
        checks++; if (MemWrite !== 1'b0) begin errors++; $display("FAIL sw_c2 memwrite=%b exp=0", MemWrite); end
        step();
        checks++; if (MemWrite !== 1'b0 || State !== 4'(MEMADR)) begin errors++; $display("FAIL sw_c3 memwrite=%b state=%0d exp 0/%0d", MemWrite, State, MEMADR); end
        step();
        checks++; if ({MemWrite, IorD, RegWrite, IRWrite} !== 4'b1100) begin errors++; $display("FAIL sw_c4 ctl=%b exp=1100", {MemWrite, IorD, RegWrite, IRWrite}); end
        step();
        checks++; if (State !== 4'(FETCH) || MemWrite !== 1'b0) begin errors++; $display("FAIL sw_c5 state=%0d memwrite=%b exp 0/0", State, MemWrite); end
    endtask

    task automatic test_rtype();
        Opcode = 6'b000000;
        Funct  = 6'b101010;
        step();
        step();
        checks++; if (State !== 4'(EXECUTE) || ALUControl !== 3'b111 || IllegalOp !== 1'b0) begin errors++; $display("FAIL slt_exec state=%0d alu=%b ill=%b exp alu=111 ill=0", State, ALUControl, IllegalOp); end
        checks++; if ({ALUSrcA, ALUSrcB} !== 3'b100) begin errors++; $display("FAIL slt_src got=%b exp=100", {ALUSrcA, ALUSrcB}); end
        step();
        checks++; if (State !== 4'(ALUWB) || {RegDst, RegWrite, MemtoReg} !== 3'b110) begin errors++; $display("FAIL slt_wb state=%0d ctl=%b exp ctl=110", State, {RegDst, RegWrite, MemtoReg}); end
        step();
        Funct = 6'b111111;
        step();
        checks++; if (IllegalOp !== 1'b0) begin errors++; $display("FAIL badf_decode ill=%b exp=0", IllegalOp); end
        step();
        checks++; if (IllegalOp !== 1'b1 || ALUControl !== 3'b010) begin errors++; $display("FAIL badf_exec ill=%b alu=%b exp 1/010", IllegalOp, ALUControl); end
        step();
        checks++; if (State !== 4'(ALUWB) || RegWrite !== 1'b0 || IllegalOp !== 1'b0) begin errors++; $display("FAIL badf_wb state=%0d rw=%b ill=%b exp rw=0 ill=0", State, RegWrite, IllegalOp); end
        step();
        checks++; if (State !== 4'(FETCH) || IllegalOp !== 1'b0) begin errors++; $display("FAIL badf_done state=%0d ill=%b exp 0/0", State, IllegalOp); end
        Funct = 6'b100000;
    endtask

    task automatic test_branch(input logic [5:0] op, input logic z, input logic exp_pcen);
        Opcode = op;
        Zero   = z;
        step();
        step();
        checks++; if (State !== 4'(BRANCH) || PCEn !== exp_pcen || PCSrc !== 2'b01 || ALUControl !== 3'b110) begin errors++; $display("FAIL branch op=%b z=%b state=%0d pcen=%b pcsrc=%b alu=%b exp pcen=%b pcsrc=01 alu=110", op, z, State, PCEn, PCSrc, ALUControl, exp_pcen); end
        step();
        checks++; if (State !== 4'(FETCH)) begin errors++; $display("FAIL branch_done state=%0d exp=0", State); end
        Zero = 1'b0;
    endtask

    task automatic test_jump();
        Opcode = 6'b000010;
        step();
        step();
        checks++; if (State !== 4'(JUMP) || PCEn !== 1'b1 || PCSrc !== 2'b10 || IRWrite !== 1'b0) begin errors++; $display("FAIL jump state=%0d pcen=%b pcsrc=%b irw=%b exp pcen=1 pcsrc=10 irw=0", State, PCEn, PCSrc, IRWrite); end
        step();
        checks++; if (State !== 4'(FETCH)) begin errors++; $display("FAIL jump_done state=%0d exp=0", State); end
    endtask

    task automatic test_immediate(input logic [5:0] op, input logic [2:0] exp_alu);
        Opcode = op;
        step();
        step();
        checks++; if (State !== 4'(IMMEXEC) || ALUControl !== exp_alu || {ALUSrcA, ALUSrcB} !== 3'b110) begin errors++; $display("FAIL imm_exec op=%b state=%0d alu=%b src=%b exp alu=%b src=110", op, State, ALUControl, {ALUSrcA, ALUSrcB}, exp_alu); end
        step();
        checks++; if (State !== 4'(IMMWB) || {RegWrite, RegDst, MemtoReg} !== 3'b100) begin errors++; $display("FAIL imm_wb state=%0d ctl=%b exp ctl=100", State, {RegWrite, RegDst, MemtoReg}); end
        step();
    endtask

    task automatic test_reset_midinstr();
        Opcode = 6'b101011;
        step();
        step();
        checks++; if (State !== 4'(MEMADR)) begin errors++; $display("FAIL abort_setup state=%0d exp=%0d", State, MEMADR); end
        rst = 1'b1;
        #1;
        checks++; if (State !== 4'(FETCH) || MemWrite !== 1'b0) begin errors++; $display("FAIL abort_now state=%0d memwrite=%b exp 0/0", State, MemWrite); end
        step();
        checks++; if (State !== 4'(FETCH) || MemWrite !== 1'b0 || IRWrite !== 1'b0) begin errors++; $display("FAIL abort_held state=%0d memwrite=%b irw=%b exp 0/0/0", State, MemWrite, IRWrite); end
        rst = 1'b0;
        Opcode = 6'b000000;
        #1;
        checks++; if (IRWrite !== 1'b1 || PCEn !== 1'b1) begin errors++; $display("FAIL abort_release irw=%b pcen=%b exp 1/1", IRWrite, PCEn); end
    endtask

    task automatic test_illegal_opcode();
        Opcode = 6'b111111;
        checks++; if (IllegalOp !== 1'b0) begin errors++; $display("FAIL illop_fetch ill=%b exp=0", IllegalOp); end
        step();
        checks++; if (State !== 4'(DECODE) || IllegalOp !== 1'b1) begin errors++; $display("FAIL illop_decode state=%0d ill=%b exp %0d/1", State, IllegalOp, DECODE); end
        step();
        checks++; if (State !== 4'(FETCH) || IllegalOp !== 1'b0) begin errors++; $display("FAIL illop_back state=%0d ill=%b exp 0/0", State, IllegalOp); end
        Opcode = 6'b000010;
    endtask

    initial begin
        test_reset();
        test_lw();
        test_sw();
        test_rtype();
        test_branch(6'b000100, 1'b1, 1'b1);
        test_branch(6'b000100, 1'b0, 1'b0);
        test_branch(6'b000101, 1'b1, 1'b0);
        test_branch(6'b000101, 1'b0, 1'b1);
        test_jump();
        test_immediate(6'b001000, 3'b010);
        test_immediate(6'b001101, 3'b001);
        test_reset_midinstr();
        test_illegal_opcode();
        test_jump();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
